// File: rtl/data_mem_resp.sv
// data_mem_resp: byte-addressable data memory with fixed-latency RISC-V style load/store responses.
module data_mem_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WLAST = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f_q, f_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   word, lwd, ld, mask, wshift, merged;
    logic          bad_f, misalign, oor, bad, commit;

    // Access decode works only on the captured request, never on live inputs.
    always_comb begin
        idx      = addr_q[AW+1:2];
        lane     = addr_q[1:0];
        word     = mem[idx];
        bad_f    = we_q ? (f_q[2] || f_q[1:0] == 2'b11)
                        : (f_q[1:0] == 2'b11 || f_q == 3'b110);
        misalign = (f_q[1:0] == 2'b01 && lane[0]) || (f_q[1:0] == 2'b10 && lane != 2'b00);
        oor      = |addr_q[31:AW+2];
        bad      = bad_f || misalign || oor;
        lwd      = word >> {lane, 3'b000};
        ld       = f_q[1:0] == 2'b10 ? lwd
                 : f_q[0] ? {{16{~f_q[2] & lwd[15]}}, lwd[15:0]}
                 : {{24{~f_q[2] & lwd[7]}}, lwd[7:0]};
        mask     = (f_q[1:0] == 2'b00 ? 32'h0000_00FF
                 : f_q[1:0] == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << {lane, 3'b000};
        wshift   = wdata_q << {lane, 3'b000};
        merged   = (word & ~mask) | (wshift & mask);
        commit   = state_q == RESP && !rst && !bad && we_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f_d     = f_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req) begin
                we_d    = we;
                f_d     = funct3;
                addr_d  = addr;
                wdata_d = wdata;
                cnt_d   = 4'd0;
                state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = cnt_q == WLAST ? RESP : WAIT;
            end
            RESP: begin
                state_d = IDLE;
                ack_d   = !bad;
                err_d   = bad;
                rdata_d = (bad || we_q) ? 32'h0 : ld;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            ack_d   = 1'b0;
            err_d   = 1'b0;
            rdata_d = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        we_q    <= we_d;
        f_q     <= f_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        ack_q   <= ack_d;
        err_q   <= err_d;
        rdata_q <= rdata_d;
    end

    // Storage is deliberately outside reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (commit) mem[idx] <= merged;
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = state_q != IDLE;
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: two instances (WAIT_CYCLES=1 and 0) checked each cycle against a transaction-level model.
module tb_data_mem_resp;
    localparam int DEPTH = 256;
    localparam int MB    = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata0, rdata1;
    logic        ack0, err0, busy0, ack1, err1, busy1;
    int          vectors = 0;
    int          miscompares = 0;
    bit          started = 0;

    always #5 clk = ~clk;

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0));
    data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata1), .ack(ack1), .err(err1), .busy(busy1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    int          wc [2] = '{1, 0};
    bit          pend [2];
    int          left [2];
    logic        c_we [2];
    logic [2:0]  c_f [2];
    logic [31:0] c_a [2], c_d [2];
    logic        e_ack [2], e_err [2], e_busy [2];
    logic [31:0] e_rd [2];
    bit          e_known [2];
    logic [7:0]  mem_m [2][MB];
    bit          mem_v [2][MB];

    function automatic bit bad_access(input logic w, input logic [2:0] f, input logic [31:0] a);
        int n;
        n = 1 << f[1:0];
        if (w ? f > 3'd2 : (f == 3'd3 || f >= 3'd6)) return 1;
        if (a % n != 0) return 1;
        return a >= MB;
    endfunction

    task automatic complete(input int k);
        int n;
        logic [31:0] v;
        bit kn;
        n = 1 << c_f[k][1:0];
        v = 0;
        kn = 1;
        if (bad_access(c_we[k], c_f[k], c_a[k])) begin
            e_err[k] = 1; e_rd[k] = 0; e_known[k] = 1;
            return;
        end
        e_ack[k] = 1;
        if (c_we[k]) begin
            for (int i = 0; i < n; i++) begin
                mem_m[k][c_a[k] + i] = c_d[k][8*i +: 8];
                mem_v[k][c_a[k] + i] = 1;
            end
            e_rd[k] = 0; e_known[k] = 1;
        end else begin
            for (int i = 0; i < n; i++) begin
                v |= 32'(mem_m[k][c_a[k] + i]) << (8 * i);
                kn &= mem_v[k][c_a[k] + i];
            end
            if (!c_f[k][2] && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
            e_rd[k] = v; e_known[k] = kn;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                pend[k] = 0; e_ack[k] = 0; e_err[k] = 0; e_busy[k] = 0; e_rd[k] = 0; e_known[k] = 1;
            end else begin
                e_ack[k] = 0; e_err[k] = 0;
                if (pend[k]) begin
                    left[k]--;
                    if (left[k] == 0) begin
                        complete(k);
                        pend[k] = 0; e_busy[k] = 0;
                    end
                end else if (req) begin
                    pend[k] = 1; left[k] = wc[k] + 1; e_busy[k] = 1;
                    c_we[k] = we; c_f[k] = funct3; c_a[k] = addr; c_d[k] = wdata;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("ack0", 32'(ack0), 32'(e_ack[0]));
            check("err0", 32'(err0), 32'(e_err[0]));
            check("busy0", 32'(busy0), 32'(e_busy[0]));
            if (e_known[0]) check("rdata0", rdata0, e_rd[0]);
            check("ack1", 32'(ack1), 32'(e_ack[1]));
            check("err1", 32'(err1), 32'(e_err[1]));
            check("busy1", 32'(busy1), 32'(e_busy[1]));
            if (e_known[1]) check("rdata1", rdata1, e_rd[1]);
        end
    end

    task automatic access(input logic w, input logic [2:0] f, input logic [31:0] a, d,
                          input bit junk, input bit abort,
                          output logic [31:0] r, output logic ok, output logic er, output int lat);
        @(negedge clk);
        req = 1; we = w; funct3 = f; addr = a; wdata = d;
        @(posedge clk);
        lat = 0; ok = 0; er = 0; r = 32'h0;
        @(negedge clk);
        if (abort) begin
            req = 0; rst = 1;
            @(posedge clk);
            @(negedge clk);
            rst = 0;
            check("abort_busy", 32'(busy0), 0);
            check("abort_ack", 32'(ack0), 0);
            check("abort_err", 32'(err0), 0);
            return;
        end
        for (int i = 0; i < 20 && !(ack0 || err0); i++) begin
            req = junk ? 1'($urandom) : 1'b0;
            if (junk) begin we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom; end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        req = 0;
        if (!(ack0 || err0)) check("timeout", 1, 0);
        r = rdata0; ok = ack0; er = err0;
    endtask

    task automatic dir(input string name, input logic w, input logic [2:0] f, input logic [31:0] a, d,
                       input logic [31:0] exp_r, input logic exp_ok);
        logic [31:0] r;
        logic ok, er;
        int lat;
        access(w, f, a, d, 0, 0, r, ok, er, lat);
        check({name, "_rdata"}, r, exp_r);
        check({name, "_ack"}, 32'(ok), 32'(exp_ok));
        check({name, "_err"}, 32'(er), 32'(!exp_ok));
        check({name, "_lat"}, lat, 2);
    endtask

    initial begin
        logic [31:0] r, a;
        logic ok, er, w;
        logic [2:0] f;
        int lat, c0, c1, t;
        rst = 1; req = 0; we = 0; funct3 = 0; addr = 0; wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        started = 1;
        check("rst_busy", 32'(busy0), 0);
        check("rst_ack", 32'(ack0), 0);
        check("rst_rdata", rdata0, 0);
        rst = 0;

        dir("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1);
        dir("lw10", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1);
        dir("sb11", 1, 3'b000, 32'h11, 32'h80, 32'h0, 1);
        dir("lb11", 0, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 1);
        dir("lbu11", 0, 3'b100, 32'h11, 32'h0, 32'h00000080, 1);
        dir("lw10b", 0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 1);
        dir("lh13", 0, 3'b001, 32'h13, 32'h0, 32'h0, 0);
        dir("lw12", 0, 3'b010, 32'h12, 32'h0, 32'h0, 0);
        dir("lw400", 0, 3'b010, 32'h400, 32'h0, 32'h0, 0);
        dir("lw10c", 0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 1);
        dir("s011", 1, 3'b011, 32'h10, 32'h0, 32'h0, 0);
        dir("lw10d", 0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 1);
        dir("l111", 0, 3'b111, 32'h10, 32'h0, 32'h0, 0);
        dir("lhu12", 0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1);
        dir("sw20", 1, 3'b010, 32'h20, 32'h11112222, 32'h0, 1);
        access(1, 3'b010, 32'h20, 32'h12345678, 0, 1, r, ok, er, lat);
        dir("lw20", 0, 3'b010, 32'h20, 32'h0, 32'h11112222, 1);

        // Continuous req: the zero-wait instance completes every second cycle.
        repeat (3) @(negedge clk);
        req = 1; we = 0; funct3 = 3'b010; addr = 32'h10;
        c0 = 0; c1 = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            c0 += int'(ack0 | err0);
            c1 += int'(ack1 | err1);
            addr = 32'(($urandom % 16) * 4);
            we = 1'($urandom % 4 == 0);
            wdata = $urandom;
        end
        req = 0;
        check("cont_dut1", c1, 10);
        check("cont_dut0", c0, 6);
        repeat (3) @(negedge clk);

        for (int it = 0; it < 200; it++) begin
            w = 1'($urandom);
            t = int'($urandom % 5);
            f = ($urandom % 4 == 0) ? 3'($urandom) : w ? 3'($urandom % 3) : 3'(t > 2 ? t + 1 : t);
            a = 32'(($urandom % 16) * 4 + (($urandom % 3 == 0) ? $urandom % 4 : 0));
            if ($urandom % 8 == 0) a = ($urandom % 2 == 0) ? $urandom : 32'(MB + $urandom % 64);
            access(w, f, a, $urandom, 1, $urandom % 30 == 0, r, ok, er, lat);
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
